// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: FSM encoding, opcodes,
// flag bit positions and the issue-record type held across an instruction.
package alu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  localparam logic [3:0] OPHI_SHIFT = 4'h8;
  localparam logic [3:0] OPHI_LUI   = 4'hF;

  localparam logic [7:0] OP_01  = 8'h01;
  localparam logic [7:0] OP_02  = 8'h02;
  localparam logic [7:0] OP_03  = 8'h03;
  localparam logic [7:0] OP_05  = 8'h05;
  localparam logic [7:0] OP_06  = 8'h06;
  localparam logic [7:0] OP_09  = 8'h09;
  localparam logic [7:0] OP_CMP = 8'h0B;
  localparam logic [7:0] OP_0D  = 8'h0D;
  localparam logic [7:0] OP_LUI = 8'hF0;

  localparam int FLG_L = 1;
  localparam int FLG_F = 2;
  localparam int FLG_Z = 3;
  localparam int FLG_N = 4;

  typedef struct packed {
    logic [7:0] opc;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] rd;
    logic       legal;
    logic       wr;
  } issue_t;

  function automatic logic op_legal(input logic [7:0] op);
    case (op)
      OP_01, OP_02, OP_03, OP_05, OP_06, OP_09, OP_CMP, OP_0D, OP_LUI: return 1'b1;
      default: return op[7:4] == OPHI_SHIFT;
    endcase
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 16-bit register file: one synchronous write port, two 8-bit operand read
// ports and one full-width debug read port, all reads combinational.
module alu_regfile #(
  parameter int NREGS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        we_i,
  input  logic [3:0]  waddr_i,
  input  logic [15:0] wdata_i,
  input  logic [3:0]  raddr_a_i,
  output logic [7:0]  rdata_a_o,
  input  logic [3:0]  raddr_b_i,
  output logic [7:0]  rdata_b_o,
  input  logic [3:0]  raddr_d_i,
  output logic [15:0] rdata_d_o
);

  logic [NREGS-1:0][15:0] mem_q;

  always_ff @(posedge clock) begin
    if (!reset) mem_q <= '0;
    else if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // The ALU datapath is 8 bits wide, so operand ports expose the low byte only.
  assign rdata_a_o = mem_q[raddr_a_i][7:0];
  assign rdata_b_o = mem_q[raddr_b_i][7:0];
  assign rdata_d_o = mem_q[raddr_d_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction at a time to a fixed-latency ALU and writes back
// its result: IDLE (accept) -> EXEC (ALU_LAT cycles) -> WB -> IDLE.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 2,
  parameter int NREGS   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inst_valid,
  input  logic [15:0] inst_data,
  output logic        inst_ready,
  output logic [7:0]  alu_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [15:0] alu_result,
  input  logic [4:0]  alu_psr,
  output logic [4:0]  flags,
  output logic        done,
  output logic        err,
  input  logic        dbg_we,
  input  logic [3:0]  dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic [15:0] dbg_rdata
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ALU_LAT - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  issue_t        issue_q, issue_d;
  logic [4:0]    flags_q;
  logic          done_q, err_q;

  logic        accept, wb, is_lui;
  logic [7:0]  rf_a, rf_b;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;

  assign inst_ready = (state_q == ST_IDLE);
  assign accept     = inst_valid && inst_ready;
  assign wb         = (state_q == ST_WB);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (inst_valid) begin
        state_d = ST_EXEC;
        cnt_d   = '0;
      end
      ST_EXEC: if (cnt_q == CNT_LAST) state_d = ST_WB;
               else cnt_d = cnt_q + CW'(1);
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // LUI carries an 8-bit immediate in place of op_lo/Rsrc.
  always_comb begin
    is_lui        = (inst_data[15:12] == OPHI_LUI);
    issue_d.opc   = is_lui ? OP_LUI : {inst_data[15:12], inst_data[7:4]};
    issue_d.a     = is_lui ? 8'h00 : rf_a;
    issue_d.b     = is_lui ? inst_data[7:0] : rf_b;
    issue_d.rd    = inst_data[11:8];
    issue_d.legal = op_legal(issue_d.opc);
    issue_d.wr    = issue_d.legal && (issue_d.opc != OP_CMP);
  end

  // Debug writes only land while idle, so they can never collide with writeback.
  assign rf_we    = wb ? issue_q.wr : (inst_ready && dbg_we);
  assign rf_waddr = wb ? issue_q.rd : dbg_addr;
  assign rf_wdata = wb ? alu_result : dbg_wdata;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      issue_q <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) issue_q <= issue_d;
      if (wb && issue_q.legal) flags_q <= alu_psr;
      done_q  <= wb;
      err_q   <= wb && !issue_q.legal;
    end
  end

  alu_regfile #(.NREGS(NREGS)) u_rf (
    .clock     (clock),
    .reset     (reset),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (inst_data[11:8]),
    .rdata_a_o (rf_a),
    .raddr_b_i (inst_data[3:0]),
    .rdata_b_o (rf_b),
    .raddr_d_i (dbg_addr),
    .rdata_d_o (dbg_rdata)
  );

  assign alu_opcode = issue_q.opc;
  assign alu_a      = issue_q.a;
  assign alu_b      = issue_q.b;
  assign flags      = flags_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU drives the result inputs, and a
// register-array model of the instruction rules predicts every observation.
module tb_alu_issue_ctrl;

  localparam int ALU_LAT = 2;
  localparam int DONE_K  = ALU_LAT + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        inst_valid = 1'b0;
  logic [15:0] inst_data = '0;
  logic        inst_ready;
  logic [7:0]  alu_opcode, alu_a, alu_b;
  logic [15:0] alu_result;
  logic [4:0]  alu_psr, flags;
  logic        done, err;
  logic        dbg_we = 1'b0;
  logic [3:0]  dbg_addr = '0;
  logic [15:0] dbg_wdata = '0;
  logic [15:0] dbg_rdata;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mR [16];
  logic [4:0]  mflags;

  logic       o_rdy, o_stable, o_err, o_lone_err;
  logic [7:0] o_opc, o_a, o_b;
  int         o_done_k, o_ndone;

  always #5 clock = ~clock;

  alu_issue_ctrl #(.ALU_LAT(ALU_LAT), .NREGS(16)) dut (
    .clock(clock), .reset(reset), .inst_valid(inst_valid), .inst_data(inst_data),
    .inst_ready(inst_ready), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_psr(alu_psr), .flags(flags), .done(done), .err(err),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
  );

  // Stand-in ALU; its operands are held steady by the controller for the whole latency.
  function automatic logic [20:0] alu_fn(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    logic [4:0]  p;
    case (op)
      8'h01: r = {8'h00, a & b};
      8'h02: r = {8'h00, a | b};
      8'h03: r = {8'h00, a ^ b};
      8'h05: r = {8'h00, a} + {8'h00, b};
      8'h06: r = {8'h00, a} - {8'h00, b};
      8'h09: r = {8'h00, a} * {8'h00, b};
      8'h0B: r = {8'h00, a} - {8'h00, b};
      8'h0D: r = {8'h00, b};
      8'hF0: r = {b, 8'h00};
      default: r = (op[7:4] == 4'h8) ? ({8'h00, a} << op[3:0]) : 16'hDEAD;
    endcase
    p    = '0;
    p[1] = a < b;
    p[2] = ({1'b0, a} + {1'b0, b}) > 9'd255;
    p[3] = (op == 8'h0B) ? (a == b) : (r == 16'h0000);
    p[4] = r[15];
    return {p, r};
  endfunction

  always_comb {alu_psr, alu_result} = alu_fn(alu_opcode, alu_a, alu_b);

  function automatic logic [7:0] exp_opc(input logic [15:0] i);
    return (i[15:12] == 4'hF) ? 8'hF0 : {i[15:12], i[7:4]};
  endfunction

  function automatic logic [7:0] exp_a(input logic [15:0] i);
    return (i[15:12] == 4'hF) ? 8'h00 : mR[i[11:8]][7:0];
  endfunction

  function automatic logic [7:0] exp_b(input logic [15:0] i);
    return (i[15:12] == 4'hF) ? i[7:0] : mR[i[3:0]][7:0];
  endfunction

  function automatic logic is_legal(input logic [7:0] op);
    return (op inside {8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h09, 8'h0B, 8'h0D, 8'hF0}) || (op[7:4] == 4'h8);
  endfunction

  task automatic model_apply(input logic [15:0] i);
    logic [7:0]  op;
    logic [20:0] res;
    op = exp_opc(i);
    if (is_legal(op)) begin
      res    = alu_fn(op, exp_a(i), exp_b(i));
      mflags = res[20:16];
      if (op != 8'h0B) mR[i[11:8]] = res[15:0];
    end
  endtask

  task automatic dbg_write(input logic [3:0] a, input logic [15:0] d);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    @(posedge clock); #1;
    dbg_we = 1'b0;
    mR[a] = d;
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [15:0] v);
    dbg_addr = a;
    #1;
    v = dbg_rdata;
  endtask

  // Drives one instruction and records what the DUT showed; tests judge the record.
  task automatic run_inst(input logic [15:0] i);
    for (int k = 0; k < 10; k++) begin
      if (inst_ready) break;
      @(posedge clock); #1;
    end
    o_rdy = inst_ready;
    inst_valid = 1'b1; inst_data = i;
    @(posedge clock); #1;
    inst_valid = 1'b0;
    o_opc = alu_opcode; o_a = alu_a; o_b = alu_b;
    o_stable = 1'b1; o_done_k = -1; o_ndone = 0; o_err = 1'b0; o_lone_err = 1'b0;
    for (int k = 1; k <= DONE_K + 3; k++) begin
      @(posedge clock); #1;
      if (alu_opcode !== o_opc || alu_a !== o_a || alu_b !== o_b) o_stable = 1'b0;
      if (done === 1'b1) begin
        o_ndone++;
        if (o_done_k < 0) begin o_done_k = k; o_err = err; end
      end
      if (err === 1'b1 && done !== 1'b1) o_lone_err = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({alu_opcode, alu_a, alu_b, flags, done, err} !== 31'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got op=%h a=%h b=%h flags=%h done=%b err=%b want all 0",
               alu_opcode, alu_a, alu_b, flags, done, err);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    vectors++;
    if (inst_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", inst_ready); end
    for (int r = 0; r < 16; r++) begin
      read_reg(r[3:0], v);
      vectors++;
      if (v !== 16'h0000) begin miscompares++; $display("FAIL reset_reg R%0d: got %h want 0000", r, v); end
      mR[r] = 16'h0000;
    end
    mflags = 5'h00;
  endtask

  task automatic test_add();
    logic [15:0] v;
    dbg_write(4'd1, 16'h0012);
    dbg_write(4'd2, 16'h0034);
    run_inst(16'h0152);
    model_apply(16'h0152);
    read_reg(4'd1, v);
    vectors++;
    if ({o_opc, o_a, o_b} !== 24'h051234) begin
      miscompares++; $display("FAIL add_issue: got %h/%h/%h want 05/12/34", o_opc, o_a, o_b);
    end
    vectors++;
    if (v !== 16'h0046) begin miscompares++; $display("FAIL add_R1: got %h want 0046", v); end
    vectors++;
    if (o_done_k != DONE_K || o_ndone != 1) begin
      miscompares++; $display("FAIL add_done: got cycle %0d count %0d want cycle %0d count 1", o_done_k, o_ndone, DONE_K);
    end
    vectors++;
    if (o_err !== 1'b0 || o_lone_err !== 1'b0) begin miscompares++; $display("FAIL add_err: got %b want 0", o_err); end
  endtask

  task automatic test_cmp();
    logic [15:0] v;
    dbg_write(4'd3, 16'h0005);
    dbg_write(4'd4, 16'h0005);
    run_inst(16'h03B4);
    model_apply(16'h03B4);
    read_reg(4'd3, v);
    vectors++;
    if (flags[3] !== 1'b1 || flags[1] !== 1'b0) begin
      miscompares++; $display("FAIL cmp_flags: got Z=%b L=%b want Z=1 L=0", flags[3], flags[1]);
    end
    vectors++;
    if (v !== 16'h0005) begin miscompares++; $display("FAIL cmp_R3: got %h want 0005", v); end
    vectors++;
    if (o_done_k != DONE_K) begin miscompares++; $display("FAIL cmp_done: got cycle %0d want %0d", o_done_k, DONE_K); end
  endtask

  task automatic test_lui();
    logic [15:0] v;
    run_inst(16'hF5AB);
    model_apply(16'hF5AB);
    read_reg(4'd5, v);
    vectors++;
    if ({o_opc, o_a, o_b} !== 24'hF000AB) begin
      miscompares++; $display("FAIL lui_issue: got %h/%h/%h want F0/00/AB", o_opc, o_a, o_b);
    end
    vectors++;
    if (o_stable !== 1'b1) begin miscompares++; $display("FAIL lui_hold: got unstable want stable"); end
    vectors++;
    if (v !== 16'hAB00) begin miscompares++; $display("FAIL lui_R5: got %h want AB00", v); end
    vectors++;
    if (flags !== mflags) begin miscompares++; $display("FAIL lui_flags: got %h want %h", flags, mflags); end
  endtask

  task automatic test_illegal();
    logic [15:0] v;
    logic [4:0]  pre;
    dbg_write(4'd1, 16'h1234);
    pre = mflags;
    run_inst(16'h0174);
    model_apply(16'h0174);
    read_reg(4'd1, v);
    vectors++;
    if (o_done_k != DONE_K || o_err !== 1'b1 || o_lone_err !== 1'b0) begin
      miscompares++; $display("FAIL ill_err: got done@%0d err=%b lone=%b want done@%0d err=1", o_done_k, o_err, o_lone_err, DONE_K);
    end
    vectors++;
    if (v !== 16'h1234) begin miscompares++; $display("FAIL ill_R1: got %h want 1234", v); end
    vectors++;
    if (flags !== pre) begin miscompares++; $display("FAIL ill_flags: got %h want %h", flags, pre); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] i1, i2, v;
    logic [3:0]  rdy;
    logic [7:0]  eo, ea, eb;
    logic        d1;
    int          dk;
    i1 = 16'h0152; i2 = 16'h0221;
    inst_valid = 1'b1; inst_data = i1;
    @(posedge clock); #1;
    inst_data = i2;
    rdy[0] = inst_ready;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clock); #1;
      rdy[k] = inst_ready;
    end
    d1 = done;
    model_apply(i1);
    eo = exp_opc(i2); ea = exp_a(i2); eb = exp_b(i2);
    @(posedge clock); #1;
    inst_valid = 1'b0;
    vectors++;
    if (rdy !== 4'b1000) begin miscompares++; $display("FAIL b2b_ready: got %b want 1000", rdy); end
    vectors++;
    if (d1 !== 1'b1) begin miscompares++; $display("FAIL b2b_done1: got %b want 1", d1); end
    vectors++;
    if (inst_ready !== 1'b0 || {alu_opcode, alu_a, alu_b} !== {eo, ea, eb}) begin
      miscompares++; $display("FAIL b2b_accept2: got rdy=%b %h/%h/%h want rdy=0 %h/%h/%h",
                              inst_ready, alu_opcode, alu_a, alu_b, eo, ea, eb);
    end
    dk = -1;
    for (int k = 1; k <= DONE_K + 2; k++) begin
      @(posedge clock); #1;
      if (done === 1'b1 && dk < 0) dk = k;
    end
    model_apply(i2);
    vectors++;
    if (dk != DONE_K) begin miscompares++; $display("FAIL b2b_done2: got cycle %0d want %0d", dk, DONE_K); end
    read_reg(4'd1, v);
    vectors++;
    if (v !== mR[1]) begin miscompares++; $display("FAIL b2b_R1: got %h want %h", v, mR[1]); end
    read_reg(4'd2, v);
    vectors++;
    if (v !== mR[2]) begin miscompares++; $display("FAIL b2b_R2: got %h want %h", v, mR[2]); end
  endtask

  task automatic test_dbg_ignored();
    logic [15:0] v;
    inst_valid = 1'b1; inst_data = 16'h0652;
    @(posedge clock); #1;
    inst_valid = 1'b0;
    dbg_we = 1'b1; dbg_addr = 4'd7; dbg_wdata = 16'hBEEF;
    repeat (DONE_K) @(posedge clock);
    #1;
    dbg_we = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    model_apply(16'h0652);
    read_reg(4'd7, v);
    vectors++;
    if (v !== mR[7]) begin miscompares++; $display("FAIL dbg_busy_R7: got %h want %h", v, mR[7]); end
    read_reg(4'd6, v);
    vectors++;
    if (v !== mR[6]) begin miscompares++; $display("FAIL dbg_busy_R6: got %h want %h", v, mR[6]); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    logic        saw_done;
    inst_valid = 1'b1; inst_data = 16'h0152;
    @(posedge clock); #1;
    inst_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    saw_done = done;
    vectors++;
    if (alu_opcode !== 8'h00 || flags !== 5'h00) begin
      miscompares++; $display("FAIL rstmid_clear: got op=%h flags=%h want 00/00", alu_opcode, flags);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    vectors++;
    if (inst_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready: got %b want 1", inst_ready); end
    for (int k = 0; k < 4; k++) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(posedge clock); #1;
    end
    vectors++;
    if (saw_done !== 1'b0) begin miscompares++; $display("FAIL rstmid_done: got %b want 0", saw_done); end
    read_reg(4'd1, v);
    vectors++;
    if (v !== 16'h0000) begin miscompares++; $display("FAIL rstmid_R1: got %h want 0000", v); end
    for (int r = 0; r < 16; r++) mR[r] = 16'h0000;
    mflags = 5'h00;
  endtask

  task automatic test_random();
    logic [7:0]  tab [8];
    logic [7:0]  op, eo, ea, eb;
    logic [3:0]  rd, rs;
    logic [15:0] i, v;
    logic        el;
    int          sel;
    tab = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h09, 8'h0B, 8'h0D};
    for (int n = 0; n < 40; n++) begin
      dbg_write(4'($urandom_range(0, 15)), 16'($urandom));
      dbg_write(4'($urandom_range(0, 15)), 16'($urandom));
      sel = int'($urandom_range(0, 9));
      rd  = 4'($urandom);
      rs  = 4'($urandom);
      op  = tab[3'($urandom_range(0, 7))];
      if (sel < 6)       i = {op[7:4], rd, op[3:0], rs};
      else if (sel == 6) i = {4'h8, rd, 4'($urandom), rs};
      else if (sel == 7) i = {4'hF, rd, 8'($urandom)};
      else               i = 16'($urandom);
      eo = exp_opc(i); ea = exp_a(i); eb = exp_b(i); el = is_legal(eo);
      run_inst(i);
      model_apply(i);
      vectors++;
      if (o_rdy !== 1'b1 || {o_opc, o_a, o_b} !== {eo, ea, eb}) begin
        miscompares++; $display("FAIL rnd_issue n=%0d inst=%h: got rdy=%b %h/%h/%h want %h/%h/%h",
                                n, i, o_rdy, o_opc, o_a, o_b, eo, ea, eb);
      end
      vectors++;
      if (o_stable !== 1'b1 || o_done_k != DONE_K || o_ndone != 1) begin
        miscompares++; $display("FAIL rnd_timing n=%0d: got stable=%b done@%0d x%0d want done@%0d x1",
                                n, o_stable, o_done_k, o_ndone, DONE_K);
      end
      vectors++;
      if (o_err !== !el || o_lone_err !== 1'b0) begin
        miscompares++; $display("FAIL rnd_err n=%0d inst=%h: got %b want %b", n, i, o_err, !el);
      end
      vectors++;
      if (flags !== mflags) begin miscompares++; $display("FAIL rnd_flags n=%0d: got %h want %h", n, flags, mflags); end
      read_reg(i[11:8], v);
      vectors++;
      if (v !== mR[i[11:8]]) begin
        miscompares++; $display("FAIL rnd_reg n=%0d R%0d: got %h want %h", n, i[11:8], v, mR[i[11:8]]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_cmp();
    test_lui();
    test_illegal();
    test_back_to_back();
    test_dbg_ignored();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter ALU_LAT, default 2, meaning ALU cycles from operand capture to valid result.
REQ-002 SHALL have parameter NREGS, default 16, meaning register-file depth; index is 4 bits.
REQ-003 SHALL have port clock  input  1  rising-edge clock, shared with the ALU.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset, shared with the ALU.
REQ-005 SHALL have port inst_valid  input  1  instruction word present.
REQ-006 SHALL have port inst_data  input  16  instruction: [15:12] op_hi, [11:8] Rdest, [7:4] op_lo, [3:0] Rsrc; LUI uses [7:0] as imm8.
REQ-007 SHALL have port inst_ready  output  1  controller can accept an instruction.
REQ-008 SHALL have port alu_opcode  output  8  opcode to the ALU.
REQ-009 SHALL have port alu_a  output  8  operand A to the ALU.
REQ-010 SHALL have port alu_b  output  8  operand B to the ALU.
REQ-011 SHALL have port alu_result  input  16  result from the ALU.
REQ-012 SHALL have port alu_psr  input  5  flags from the ALU: [1] L, [2] F, [3] Z, [4] N.
REQ-013 SHALL have port flags  output  5  last latched alu_psr.
REQ-014 SHALL have port done  output  1  one-cycle pulse on instruction completion.
REQ-015 SHALL have port err  output  1  one-cycle pulse, coincident with done, for an unsupported opcode.
REQ-016 SHALL have debug ports dbg_we in 1, dbg_addr in 4, dbg_wdata in 16, dbg_rdata out 16: combinational read, write honoured only in IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE; inst_ready=1 only in IDLE.
REQ-018 Accept on inst_valid&&inst_ready at edge A; at A register alu_opcode, alu_a, alu_b and the decoded fields; enter EXEC.
REQ-019 Register ops: alu_opcode={op_hi,op_lo}, alu_a=R[Rdest][7:0], alu_b=R[Rsrc][7:0].
REQ-020 LUI (op_hi=4'hF): alu_opcode=8'hF0, alu_b=imm8, alu_a=0.
REQ-021 Shifts (op_hi=4'h8): alu_opcode={4'h8,op_lo}, operands per REQ-019.
REQ-022 Supported opcodes: 01,02,03,05,06,09,0B,0D, 80-8F, F0; all others are illegal.
REQ-023 alu_opcode/alu_a/alu_b SHALL hold stable from edge A until the next accept.
REQ-024 EXEC lasts ALU_LAT cycles (A+1..A+ALU_LAT); enter WB at edge A+ALU_LAT.
REQ-025 At edge A+ALU_LAT+1 (WB): R[Rdest]<=alu_result, flags<=alu_psr, done=1 for the following cycle; return to IDLE.
REQ-026 CMP (0B): no register write; flags SHALL be updated.
REQ-027 Illegal opcode: no register write, flags unchanged, err=1 with done.
REQ-028 Full 16-bit result written; no truncation or sign extension.
REQ-029 Throughput: next accept earliest at edge A+ALU_LAT+2; inst_valid held high is not re-accepted earlier.
REQ-030 dbg_we outside IDLE SHALL be ignored; WB write and dbg write never coincide by construction.

Reset
REQ-031 reset=0 at any edge: FSM->IDLE, all registers, flags, alu_* outputs =0, done=err=0; in-flight instruction discarded without writeback.
REQ-032 inst_ready=1 at the first edge after reset deasserts.

Structure
REQ-033 Opcode constants, FSM state encoding and flag bit indices SHALL reside in shared package alu_pkg.
REQ-034 Register file SHALL be sub-module alu_regfile (1 write, 2 read + 1 debug read port, synchronous write).

Verification
REQ-035 dbg write R1=0x0012, R2=0x0034; inst 0x0152 accepted at A -> R1=0x0046, done high in cycle after edge A+3, err=0.
REQ-036 R3=R4=0x0005; inst 0x03B4 -> flags[3]=1, flags[1]=0, R3 still 0x0005.
REQ-037 inst 0xF5AB -> R5=0xAB00; alu_b=0xAB, alu_opcode=0xF0 from A to A+3.
REQ-038 inst 0x0174 (opcode 0x07) -> err and done together, R1 unchanged, flags unchanged.
REQ-039 inst_valid held high with two instructions -> inst_ready low for three cycles, second accepted at A+4.
REQ-040 reset=0 during EXEC of 0x0152 -> R1=0, no done, inst_ready=1 one edge after reset release.
